lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- MEM-stage load/store initiator that drives a word-organised data-memory port with a req/ack handshake.
- Computes the effective address and checks alignment and operation legality.
- Forms byte enables and lane-replicated store data, stalls the pipeline while an access is outstanding, and returns sign- or zero-extended load data.
- Type encoding is the core's standard one: 000 byte signed, 001 half signed, 010 word, 011 byte unsigned, 100 half unsigned.

Parameters:
TIMEOUT, 16, cycles in ACCESS without mem_ack before the access is aborted; must be at least 2.
CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
op_valid  in  1  MEM stage presents a memory operation
op_store  in  1  1 = store, 0 = load
op_type  in  3  access type code (encoding above)
base  in  32  rs1 value
offset  in  32  immediate
store_data  in  32  rs2 value
stall  out  1  hold pipeline registers upstream of MEM
load_valid  out  1  one-cycle pulse: load_data is valid
load_data  out  32  extended load result
misaligned  out  1  one-cycle pulse: alignment fault, no access made
bus_err  out  1  one-cycle pulse: illegal type or timeout
mem_req  out  1  request to data memory
mem_we  out  1  write enable
mem_addr  out  32  word address: effective address [31:2], low two bits 00
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completes the request this cycle
mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Effective address: ea = base + offset, modulo 2^32, carry discarded; lane = ea[1:0].
- States: IDLE, ACCESS, DONE.
- Reset (synchronous): state IDLE, counter 0, load_data 0, latched request fields 0.
  - All outputs read 0 while in IDLE with op_valid=0.
  - Reset during ACCESS: mem_req is low from the next cycle; any ack arriving afterwards is ignored.
- IDLE, op_valid=1, legal and aligned:
  - stall=1 combinationally in the same cycle.
  - ea, type, store flag and formatted wdata/be are latched; next state is ACCESS.
- Illegal operation: any type code above 100, or a store with type above 010.
  - bus_err=1 for that cycle; stall=0; no memory access; state stays IDLE.
- Misaligned: half access with ea[0]=1, or word access with ea[1:0]≠00.
  - misaligned=1 for that cycle; stall=0; no access; state stays IDLE.
  - Illegal type takes priority over misalignment.
- ACCESS:
  - mem_req=1 and stall=1; mem_we, mem_addr, mem_be, mem_wdata are held constant until the ack.
  - Counter increments each cycle spent in ACCESS.
  - mem_ack=1: next state is DONE. For a load, mem_rdata is formatted into load_data at that edge.
  - No ack and counter = TIMEOUT-1: mem_req drops, bus_err is flagged for DONE, next state is DONE.
  - Ack and timeout in the same cycle: the ack wins.
- DONE (exactly one cycle):
  - stall=0; the pipeline advances at the end of this cycle.
  - load_valid=1 only for a successfully completed load; bus_err=1 if the access timed out.
  - op_valid is ignored in DONE, since it still holds the completed op. Counter clears; next state is IDLE.
- Minimum occupancy: 3 cycles per access (accept, ACCESS with ack, DONE). Each added memory wait state adds one cycle.
- mem_ack outside ACCESS is ignored.
- Byte enables:
  - byte: 0001 shifted left by lane
  - half: 0011 shifted left by lane
  - word: 1111
  - loads drive the same be pattern with mem_we=0
- Store data:
  - byte: store_data[7:0] replicated 4 times
  - half: store_data[15:0] replicated 2 times
  - word: unchanged
- Load formatting: shift mem_rdata right by 8*lane, then:
  - types 000/001: sign-extend from bit 7 / bit 15
  - types 011/100: zero-extend
  - type 010: the whole word
- load_data holds its value until the next completed load or reset.

Decomposition:
- Shared package lsu_pkg holds:
  - type codes TYPE_B, TYPE_H, TYPE_W, TYPE_BU, TYPE_HU
  - state encodings ST_IDLE, ST_ACCESS, ST_DONE
  - byte-enable base patterns
- One combinational sub-module, lsu_lane_fmt, performs store replication, byte-enable generation and load extract/extension. It is instantiated once and reused by the top-level FSM.

Test Plan:
- LB, base 0x100, offset 3, ack in first ACCESS cycle, mem_rdata 0x80112233:
  - mem_addr 0x100, be 1000
  - load_data 0xFFFFFF80, load_valid in cycle 3
  - stall high for cycles 1–2
- SH, base 0x200, offset 2, store_data 0x1234ABCD, ack after 2 wait cycles:
  - mem_we 1, be 1100, wdata 0xABCDABCD
  - fields stable across all 3 ACCESS cycles; no load_valid
- LHU at ea 0x0000_0301:
  - misaligned pulse, no mem_req, stall 0, state remains IDLE
- LW at ea 0x400 with TIMEOUT=4 and mem_ack never asserted:
  - mem_req high for exactly 4 cycles
  - then bus_err pulse in DONE, load_valid 0, return to IDLE
- Store with type 011:
  - bus_err pulse, no mem_req
- Reset during ACCESS, then a late ack:
  - mem_req 0 on the next cycle, late ack ignored, all outputs 0
  - next LW at ea 0x8, mem_rdata 0xDEADBEEF: load_data 0xDEADBEEF

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store initiator: type codes,
// FSM states, byte-enable base patterns and the latched request record.
package lsu_pkg;

    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b011;
    localparam logic [2:0] TYPE_HU = 3'b100;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        store;
        logic [2:0]  typ;
        logic [1:0]  lane;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_req_t;

    // Stores only exist for the signed/word codes; anything above HU is undefined.
    function automatic logic type_illegal(input logic store, input logic [2:0] typ);
        logic bad;
        bad = (typ > TYPE_HU) || (store && (typ > TYPE_W));
        return bad;
    endfunction

    function automatic logic type_misaligned(input logic [2:0] typ, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (typ)
            TYPE_H, TYPE_HU: bad = lane[0];
            TYPE_W:          bad = (lane != 2'b00);
            default:         bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Lane formatter: byte-enable generation, store-data replication and
// load extract with sign/zero extension for a given type and lane.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  op_type,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_val
);

    logic [31:0] shifted;

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        be    = BE_WORD;
        wdata = store_data;
        case (op_type)
            TYPE_B, TYPE_BU: begin
                be    = BE_BYTE << lane;
                wdata = {4{store_data[7:0]}};
            end
            TYPE_H, TYPE_HU: begin
                be    = BE_HALF << lane;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = BE_WORD;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        load_val = shifted;
        case (op_type)
            TYPE_B:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            TYPE_H:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            TYPE_BU: load_val = {24'h0, shifted[7:0]};
            TYPE_HU: load_val = {16'h0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: validates an op, runs one req/ack access on
// the word-organised data port with a timeout, and returns formatted load data.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [2:0]  op_type,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Valid/ready contract: an op is taken in IDLE in the cycle op_valid is high
    // and stall is low only when it is rejected; mem_req stays high, with all
    // request fields stable, until the cycle mem_ack is seen (or the timeout).

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    lsu_req_t         req;
    logic             req_q;
    logic             load_valid_q;
    logic             timeout_q;

    logic [31:0] ea;
    logic        in_idle;
    logic        op_illegal;
    logic        op_unaligned;
    logic        accept;
    logic [2:0]  fmt_type;
    logic [1:0]  fmt_lane;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_load;

    assign ea           = base + offset;
    assign in_idle      = (state == ST_IDLE) && op_valid;
    assign op_illegal   = in_idle && type_illegal(op_store, op_type);
    assign op_unaligned = in_idle && !type_illegal(op_store, op_type)
                          && type_misaligned(op_type, ea[1:0]);
    assign accept       = in_idle && !op_illegal && !op_unaligned;

    // One formatter serves both phases: the incoming op while idle, the latched op during ACCESS.
    assign fmt_type = (state == ST_ACCESS) ? req.typ  : op_type;
    assign fmt_lane = (state == ST_ACCESS) ? req.lane : ea[1:0];

    lsu_lane_fmt u_fmt (
        .op_type    (fmt_type),
        .lane       (fmt_lane),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .load_val   (fmt_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req          <= '0;
            req_q        <= 1'b0;
            load_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            load_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req.store <= op_store;
                        req.typ   <= op_type;
                        req.lane  <= ea[1:0];
                        req.addr  <= {ea[31:2], 2'b00};
                        req.be    <= fmt_be;
                        req.wdata <= op_store ? fmt_wdata : 32'h0;
                        req_q     <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack) begin
                        req_q <= 1'b0;
                        state <= ST_DONE;
                        if (!req.store) begin
                            load_data    <= fmt_load;
                            load_valid_q <= 1'b1;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    cnt          <= '0;
                    load_valid_q <= 1'b0;
                    timeout_q    <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall      = accept || (state == ST_ACCESS);
    assign load_valid = load_valid_q;
    assign misaligned = op_unaligned;
    assign bus_err    = op_illegal || timeout_q;

    // Request fields are qualified by mem_req so the port reads all-zero when idle.
    assign mem_req   = req_q;
    assign mem_we    = req_q && req.store;
    assign mem_addr  = req_q ? req.addr  : 32'h0;
    assign mem_be    = req_q ? req.be    : 4'h0;
    assign mem_wdata = req_q ? req.wdata : 32'h0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed vector table, reset/late-ack sequence,
// and randomized ops checked against a spec-level reference model.
module tb_lsu_mem_initiator;

    localparam int TIMEOUT = 4;
    localparam int K_ACC = 0;
    localparam int K_MIS = 1;
    localparam int K_ERR = 2;

    typedef struct {
        logic        store;
        logic [2:0]  typ;
        logic [31:0] base;
        logic [31:0] offset;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_store = 1'b0;
    logic [2:0]  op_type = 3'b0;
    logic [31:0] base = 32'h0;
    logic [31:0] offset = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ld = 32'h0;
    vec_t        tbl[$];

    lsu_mem_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_store   (op_store),
        .op_type    (op_type),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " stall"}, {31'h0, stall}, 32'h0);
        chk({tag, " mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, " load_valid"}, {31'h0, load_valid}, 32'h0);
        chk({tag, " bus_err"}, {31'h0, bus_err}, 32'h0);
        chk({tag, " misaligned"}, {31'h0, misaligned}, 32'h0);
        chk({tag, " mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, " mem_addr"}, mem_addr, 32'h0);
        chk({tag, " mem_be"}, {28'h0, mem_be}, 32'h0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, " load_data"}, load_data, exp_ld);
    endtask

    function automatic vec_t vec(input logic st, input logic [2:0] t, input logic [31:0] b,
                                 input logic [31:0] o, input logic [31:0] sd, input logic [31:0] rd,
                                 input int w, input int k, input logic [31:0] a, input logic [3:0] e,
                                 input logic [31:0] wd, input logic [31:0] ld);
        vec_t v;
        v.store = st; v.typ = t; v.base = b; v.offset = o; v.sdata = sd; v.rdata = rd;
        v.waits = w; v.kind = k; v.addr = a; v.be = e; v.wdata = wd; v.ldata = ld;
        return v;
    endfunction

    // Reference model: access size in bytes, address arithmetic and byte-wise replication.
    function automatic vec_t model(input vec_t i);
        vec_t        v;
        logic [31:0] ea;
        logic [31:0] val;
        logic [31:0] mask;
        int          size;
        int          lane;
        bit          sgn;
        v = i;
        ea = i.base + i.offset;
        lane = int'(ea % 4);
        sgn = 1'b0;
        case (i.typ)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd3: size = 1;
            3'd4: size = 2;
            default: size = 0;
        endcase
        if (size == 0 || (i.store && i.typ > 3'd2)) v.kind = K_ERR;
        else if (ea % size != 0) v.kind = K_MIS;
        else v.kind = K_ACC;
        if (size == 0) size = 4;
        v.addr = ea - 32'(lane);
        v.be = 4'(((1 << size) - 1) << lane);
        for (int b = 0; b < 4; b++) v.wdata[8*b +: 8] = i.sdata[8*(b % size) +: 8];
        val = i.rdata >> (8 * lane);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        val = val & mask;
        if (sgn && val[8*size-1]) val = val | ~mask;
        v.ldata = val;
        return v;
    endfunction

    task automatic run_op(input vec_t o);
        bit timeout;
        int n;
        @(posedge clk); #1;
        op_valid = 1'b1; op_store = o.store; op_type = o.typ;
        base = o.base; offset = o.offset; store_data = o.sdata;
        mem_rdata = o.rdata; mem_ack = 1'b0;
        #1;
        if (o.kind != K_ACC) begin
            chk("reject misaligned", {31'h0, misaligned}, {31'h0, o.kind == K_MIS});
            chk("reject bus_err", {31'h0, bus_err}, {31'h0, o.kind == K_ERR});
            chk("reject stall", {31'h0, stall}, 32'h0);
            chk("reject mem_req", {31'h0, mem_req}, 32'h0);
            @(posedge clk); #1;
            op_valid = 1'b0;
            #1;
            chk_quiet("after reject");
        end else begin
            chk("accept stall", {31'h0, stall}, 32'h1);
            chk("accept mem_req", {31'h0, mem_req}, 32'h0);
            chk("accept errs", {30'h0, bus_err, misaligned}, 32'h0);
            timeout = (o.waits >= TIMEOUT);
            n = timeout ? TIMEOUT : o.waits + 1;
            for (int i = 0; i < n; i++) begin
                @(posedge clk); #1;
                mem_ack = (!timeout && i == o.waits);
                #1;
                chk("acc mem_req", {31'h0, mem_req}, 32'h1);
                chk("acc stall", {31'h0, stall}, 32'h1);
                chk("acc mem_we", {31'h0, mem_we}, {31'h0, o.store});
                chk("acc mem_addr", mem_addr, o.addr);
                chk("acc mem_be", {28'h0, mem_be}, {28'h0, o.be});
                if (o.store) chk("acc mem_wdata", mem_wdata, o.wdata);
                chk("acc load_valid", {31'h0, load_valid}, 32'h0);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            #1;
            if (!o.store && !timeout) exp_ld = o.ldata;
            chk("done stall", {31'h0, stall}, 32'h0);
            chk("done mem_req", {31'h0, mem_req}, 32'h0);
            chk("done load_valid", {31'h0, load_valid}, {31'h0, !o.store && !timeout});
            chk("done bus_err", {31'h0, bus_err}, {31'h0, timeout});
            chk("done load_data", load_data, exp_ld);
            @(posedge clk); #1;
            op_valid = 1'b0;
            #1;
            chk_quiet("back to idle");
        end
    endtask

    initial begin
        vec_t r;
        tbl.push_back(vec(0, 3'd0, 32'h100, 32'h3, 32'h0, 32'h80112233, 0, K_ACC, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80));
        tbl.push_back(vec(1, 3'd1, 32'h200, 32'h2, 32'h1234ABCD, 32'h0, 2, K_ACC, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0));
        tbl.push_back(vec(0, 3'd4, 32'h300, 32'h1, 32'h0, 32'h0, 0, K_MIS, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vec(0, 3'd2, 32'h400, 32'h0, 32'h0, 32'h0, 99, K_ACC, 32'h400, 4'b1111, 32'h0, 32'h0));
        tbl.push_back(vec(1, 3'd3, 32'h0, 32'h0, 32'h0, 32'h0, 0, K_ERR, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vec(0, 3'd1, 32'h10, 32'hFFFFFFF2, 32'h0, 32'h80017FFF, 3, K_ACC, 32'h0, 4'b1100, 32'h0, 32'hFFFF8001));
        tbl.push_back(vec(0, 3'd3, 32'h20, 32'h1, 32'h0, 32'h1234F0AB, 1, K_ACC, 32'h20, 4'b0010, 32'h0, 32'h000000F0));
        tbl.push_back(vec(1, 3'd0, 32'hFFFFFFFF, 32'h2, 32'h5A, 32'h0, 0, K_ACC, 32'h0, 4'b0010, 32'h5A5A5A5A, 32'h0));
        tbl.push_back(vec(1, 3'd2, 32'h1000, 32'h4, 32'hCAFEF00D, 32'h0, 1, K_ACC, 32'h1004, 4'b1111, 32'hCAFEF00D, 32'h0));
        tbl.push_back(vec(0, 3'd5, 32'h0, 32'h0, 32'h0, 32'h0, 0, K_ERR, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vec(0, 3'd7, 32'h0, 32'h0, 32'h0, 32'h0, 0, K_ERR, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vec(1, 3'd2, 32'h1000, 32'h2, 32'h0, 32'h0, 0, K_MIS, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vec(1, 3'd4, 32'h0, 32'h0, 32'h0, 32'h0, 0, K_ERR, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vec(1, 3'd5, 32'h1, 32'h0, 32'h0, 32'h0, 0, K_ERR, 32'h0, 4'h0, 32'h0, 32'h0));
        tbl.push_back(vec(0, 3'd0, 32'h0, 32'h7, 32'h0, 32'h7F000000, 0, K_ACC, 32'h4, 4'b1000, 32'h0, 32'h0000007F));

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk_quiet("reset");

        foreach (tbl[i]) run_op(tbl[i]);

        // Reset in the middle of an access, then an ack that arrives too late.
        @(posedge clk); #1;
        op_valid = 1'b1; op_store = 1'b0; op_type = 3'd2;
        base = 32'h500; offset = 32'h0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset mem_req", {31'h0, mem_req}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        exp_ld = 32'h0;
        #1 chk_quiet("reset in access");
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1 chk_quiet("late ack");
        run_op(vec(0, 3'd2, 32'h0, 32'h8, 32'h0, 32'hDEADBEEF, 0, K_ACC, 32'h8, 4'b1111, 32'h0, 32'hDEADBEEF));

        for (int k = 0; k < 40; k++) begin
            r = vec($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, 32'($urandom_range(0, 64)),
                    $urandom, $urandom, $urandom_range(0, TIMEOUT + 1), K_ACC, 32'h0, 4'h0, 32'h0, 32'h0);
            if ($urandom_range(0, 1) == 1) begin
                r.base[1:0] = 2'b00;
                r.offset[1:0] = 2'b00;
            end
            run_op(model(r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
